// File: rtl/estado_fsm_ctrl_if.sv
// Front-panel / display bundle for the sequence controller.
// The master drives the buttons and sensor and reads the state code; the
// controller is the slave.
interface estado_fsm_ctrl_if;
    logic       btn_start;
    logic       btn_stop;
    logic       sensor;
    logic [2:0] estado;
    logic       busy;
    logic       fault;

    modport master (
        output btn_start,
        output btn_stop,
        output sensor,
        input  estado,
        input  busy,
        input  fault
    );

    modport slave (
        input  btn_start,
        input  btn_stop,
        input  sensor,
        output estado,
        output busy,
        output fault
    );
endinterface

// File: rtl/estado_fsm_ctrl.sv
// Five-state sequence controller for the 7-segment state display.
// Buttons and sensor are synchronized (two flops each); buttons are turned
// into single-cycle rising-edge pulses. estado, busy and fault are all
// registered from the next-state decode so they always change together.
module estado_fsm_ctrl #(
    parameter int          CNT_W  = 24,
    parameter int unsigned T_STEP = 10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    estado_fsm_ctrl_if.slave   bus
);

    localparam logic [2:0] S0_IDLE     = 3'b000;
    localparam logic [2:0] S1_ARRANQUE = 3'b001;
    localparam logic [2:0] S2_OPERA    = 3'b010;
    localparam logic [2:0] S3_FINAL    = 3'b011;
    localparam logic [2:0] S4_FALLA    = 3'b100;

    // Last counter value of a timed state: the transition fires on the edge
    // after the counter reaches it, so the state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] C_DWELL_LAST   = CNT_W'(T_STEP - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(4 * T_STEP - 1);

    // Bit order: [0]=start, [1]=stop, [2]=sensor
    logic [2:0]       w_async;
    logic [2:0]       r_sync0;
    logic [2:0]       r_sync1;
    logic [1:0]       r_btn_d;
    logic             w_start_p;
    logic             w_stop_p;
    logic             w_sensor_s;

    logic [2:0]       r_estado;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_fault;

    logic [2:0]       w_estado_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_busy_next;
    logic             w_fault_next;

    assign w_async = {bus.sensor, bus.btn_stop, bus.btn_start};

    // Two-flop synchronizer for every asynchronous input, plus a delay stage
    // on the buttons for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 3'b000;
            r_sync1 <= 3'b000;
            r_btn_d <= 2'b00;
        end else begin
            r_sync0 <= w_async;
            r_sync1 <= r_sync0;
            r_btn_d <= r_sync1[1:0];
        end
    end

    // A held button yields only one pulse because the delayed copy catches up.
    assign w_start_p  = r_sync1[0] & ~r_btn_d[0];
    assign w_stop_p   = r_sync1[1] & ~r_btn_d[1];
    assign w_sensor_s = r_sync1[2];

    // Next-state decode; priority is stop, then sensor, then dwell expiry,
    // then start.
    always_comb begin
        w_estado_next = r_estado;
        case (r_estado)
            S0_IDLE: begin
                if (w_start_p)
                    w_estado_next = S1_ARRANQUE;
            end
            S1_ARRANQUE: begin
                if (w_stop_p)
                    w_estado_next = S4_FALLA;
                else if (r_cnt == C_DWELL_LAST)
                    w_estado_next = S2_OPERA;
            end
            S2_OPERA: begin
                if (w_stop_p)
                    w_estado_next = S4_FALLA;
                else if (w_sensor_s)
                    w_estado_next = S3_FINAL;
                else if (r_cnt == C_TIMEOUT_LAST)
                    w_estado_next = S4_FALLA;
            end
            S3_FINAL: begin
                if (w_stop_p)
                    w_estado_next = S4_FALLA;
                else if (r_cnt == C_DWELL_LAST)
                    w_estado_next = S0_IDLE;
            end
            S4_FALLA: begin
                // Start together with stop is treated as still aborting.
                if (w_start_p && !w_stop_p)
                    w_estado_next = S0_IDLE;
            end
            default: w_estado_next = S0_IDLE;
        endcase
    end

    // Dwell counter: restarts on any state change, idles at 0 in the untimed
    // states, otherwise counts while the state holds.
    always_comb begin
        w_cnt_next = '0;
        if (w_estado_next == r_estado &&
            r_estado != S0_IDLE && r_estado != S4_FALLA)
            w_cnt_next = r_cnt + 1'b1;
    end

    // Status flags decoded from the next state so they line up with estado.
    always_comb begin
        w_busy_next  = (w_estado_next == S1_ARRANQUE) ||
                       (w_estado_next == S2_OPERA)    ||
                       (w_estado_next == S3_FINAL);
        w_fault_next = (w_estado_next == S4_FALLA);
    end

    // State, counter and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= S0_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_estado <= w_estado_next;
            r_cnt    <= w_cnt_next;
            r_busy   <= w_busy_next;
            r_fault  <= w_fault_next;
        end
    end

    assign bus.estado = r_estado;
    assign bus.busy   = r_busy;
    assign bus.fault  = r_fault;

endmodule

// File: tb/tb_estado_fsm_ctrl.sv
// Directed bench for estado_fsm_ctrl with T_STEP=4, CNT_W=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_estado_fsm_ctrl;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    estado_fsm_ctrl_if bus ();

    estado_fsm_ctrl #(
        .CNT_W  (8),
        .T_STEP (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare {estado, busy, fault} against the expected triple.
    task automatic chk(input string tag, input logic [2:0] est,
                       input logic busy_e, input logic fault_e);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {bus.estado, bus.busy, bus.fault};
        exp = {est, busy_e, fault_e};
        tests_run++;
        assert (obs === exp)
            $display("[TB] %-14s estado=%b busy=%b fault=%b ok", tag,
                     obs[4:2], obs[1], obs[0]);
        else begin
            tests_failed++;
            $error("FAIL %s observed estado/busy/fault=%b/%b/%b expected=%b/%b/%b",
                   tag, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // One-cycle start pulse; returns just after edge 3, where estado moves.
    task automatic pulse_start();
        bus.btn_start = 1'b1;
        tick();
        bus.btn_start = 1'b0;
        tick(2);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.btn_start = 1'b0;
        bus.btn_stop  = 1'b0;
        bus.sensor    = 1'b0;

        // Reset values
        #1;
        chk("reset_t0", 3'b000, 1'b0, 1'b0);
        tick(2);
        chk("reset_clk", 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(2);
        chk("idle", 3'b000, 1'b0, 1'b0);

        // Test 1: start pulse, latency and S1 dwell
        bus.btn_start = 1'b1;
        tick();
        bus.btn_start = 1'b0;
        tick();
        chk("t1_edge2", 3'b000, 1'b0, 1'b0);
        tick();
        chk("t1_edge3", 3'b001, 1'b1, 1'b0);
        tick(3);
        chk("t1_s1_last", 3'b001, 1'b1, 1'b0);
        tick();
        chk("t1_to_s2", 3'b010, 1'b1, 1'b0);

        // Test 2: sensor in S2 -> S3 -> S0
        bus.sensor = 1'b1;
        tick(2);
        chk("t2_edge2", 3'b010, 1'b1, 1'b0);
        tick();
        chk("t2_to_s3", 3'b011, 1'b1, 1'b0);
        bus.sensor = 1'b0;
        tick(3);
        chk("t2_s3_last", 3'b011, 1'b1, 1'b0);
        tick();
        chk("t2_to_s0", 3'b000, 1'b0, 1'b0);

        // Test 3: S2 timeout after 16 cycles
        pulse_start();
        chk("t3_s1", 3'b001, 1'b1, 1'b0);
        tick(4);
        chk("t3_s2", 3'b010, 1'b1, 1'b0);
        tick(15);
        chk("t3_s2_last", 3'b010, 1'b1, 1'b0);
        tick();
        chk("t3_timeout", 3'b100, 1'b0, 1'b1);

        // Test 4: stop beats sensor; start+stop holds S4; start alone clears
        pulse_start();
        chk("t4_clear", 3'b000, 1'b0, 1'b0);
        pulse_start();
        chk("t4_s1", 3'b001, 1'b1, 1'b0);
        tick(4);
        chk("t4_s2", 3'b010, 1'b1, 1'b0);
        bus.btn_stop = 1'b1;
        bus.sensor   = 1'b1;
        tick(3);
        chk("t4_stop_wins", 3'b100, 1'b0, 1'b1);
        bus.btn_stop = 1'b0;
        bus.sensor   = 1'b0;
        tick(3);
        bus.btn_start = 1'b1;
        bus.btn_stop  = 1'b1;
        tick();
        bus.btn_start = 1'b0;
        bus.btn_stop  = 1'b0;
        tick(2);
        chk("t4_both_e3", 3'b100, 1'b0, 1'b1);
        tick(3);
        chk("t4_both_hold", 3'b100, 1'b0, 1'b1);
        pulse_start();
        chk("t4_start_s0", 3'b000, 1'b0, 1'b0);

        // Test 5: asynchronous reset mid-S1
        pulse_start();
        chk("t5_s1", 3'b001, 1'b1, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_rst", 3'b000, 1'b0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick();
        pulse_start();
        chk("t5_restart", 3'b001, 1'b1, 1'b0);
        tick(4);
        chk("t5_s2", 3'b010, 1'b1, 1'b0);

        // Test 6: held start gives one transition only
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_idle", 3'b000, 1'b0, 1'b0);
        bus.btn_start = 1'b1;
        tick(2);
        chk("t6_edge2", 3'b000, 1'b0, 1'b0);
        tick();
        chk("t6_s1", 3'b001, 1'b1, 1'b0);
        tick(4);
        chk("t6_s2", 3'b010, 1'b1, 1'b0);
        tick(16);
        chk("t6_timeout", 3'b100, 1'b0, 1'b1);
        // 23 cycles used so far; keep the button held for the rest of 50.
        for (int c = 0; c < 27; c++) begin
            tick();
            chk("t6_held_s4", 3'b100, 1'b0, 1'b1);
        end
        bus.btn_start = 1'b0;
        tick(3);
        chk("t6_release", 3'b100, 1'b0, 1'b1);
        pulse_start();
        chk("t6_rearm_s0", 3'b000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
